// File: rtl/execute_unit.sv
// execute_unit: MIPS execute stage with single-cycle ALU/shift/immediate ops
// and iterative MULT/MULTU/DIV/DIVU writing the architectural HI/LO pair.
// Ports: clock/reset (async, active-high); in_valid/in_ready + insn/pc/rs/rt
// in; out_valid/data_out/overflow out (1-cycle latency); busy while mul/div.
module execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      insn,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             overflow,
  output logic             busy
);
  localparam int SHW    = $clog2(WIDTH);
  localparam int LUI_SH = (WIDTH >= 16) ? WIDTH - 16 : 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rs_sv_q, rs_sv_d; // original dividend for divide-by-zero
  logic               div_q, div_d;
  logic               neg_q, neg_d;     // product / quotient is negative
  logic               rneg_q, rneg_d;   // remainder takes dividend sign
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               out_valid_q, out_valid_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic [5:0]       opcode, func;
  logic [WIDTH-1:0] imm_s, imm_z, lui_val, add_r, sub_r, addi_r, res;
  logic [SHW-1:0]   sa_sh, rs_sh;
  logic             fire, md_start, md_div, md_signed, ovf;
  logic             unused_bits;

  assign opcode  = insn[31:26];
  assign func    = insn[5:0];
  assign imm_s   = WIDTH'($signed(insn[15:0]));
  assign imm_z   = WIDTH'(insn[15:0]);
  assign lui_val = (WIDTH >= 16) ? (WIDTH'(insn[15:0]) << LUI_SH) : '0;
  assign sa_sh   = SHW'(insn[10:6]);
  assign rs_sh   = rs[SHW-1:0];
  assign add_r   = rs + rt;
  assign sub_r   = rs - rt;
  assign addi_r  = rs + imm_s;
  assign unused_bits = ^insn[25:16];

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign fire      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign overflow  = ovf_q;

  // Decode and single-cycle result. Unknown encodings fall through to 0.
  always_comb begin
    res       = '0;
    ovf       = 1'b0;
    md_start  = 1'b0;
    md_div    = 1'b0;
    md_signed = 1'b0;
    case (opcode)
      6'h00: begin
        case (func)
          6'h00: res = rt << sa_sh;
          6'h02: res = rt >> sa_sh;
          6'h03: res = WIDTH'($signed(rt) >>> sa_sh);
          6'h04: res = rt << rs_sh;
          6'h06: res = rt >> rs_sh;
          6'h07: res = WIDTH'($signed(rt) >>> rs_sh);
          6'h09: res = pc + WIDTH'(8);
          6'h10: res = hi_q;
          6'h12: res = lo_q;
          6'h18: begin md_start = 1'b1; md_signed = 1'b1; end
          6'h19: md_start = 1'b1;
          6'h1A: begin md_start = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
          6'h1B: begin md_start = 1'b1; md_div = 1'b1; end
          6'h20: begin
            res = add_r;
            ovf = (rs[WIDTH-1] == rt[WIDTH-1]) && (add_r[WIDTH-1] != rs[WIDTH-1]);
          end
          6'h21: res = add_r;
          6'h22: begin
            res = sub_r;
            ovf = (rs[WIDTH-1] != rt[WIDTH-1]) && (sub_r[WIDTH-1] != rs[WIDTH-1]);
          end
          6'h23: res = sub_r;
          6'h24: res = rs & rt;
          6'h25: res = rs | rt;
          6'h26: res = rs ^ rt;
          6'h27: res = ~(rs | rt);
          6'h2A: res = WIDTH'($signed(rs) < $signed(rt));
          6'h2B: res = WIDTH'(rs < rt);
          default: res = '0;
        endcase
      end
      6'h08: begin
        res = addi_r;
        ovf = (rs[WIDTH-1] == imm_s[WIDTH-1]) && (addi_r[WIDTH-1] != rs[WIDTH-1]);
      end
      6'h09: res = addi_r;
      6'h0A: res = WIDTH'($signed(rs) < $signed(imm_s));
      6'h0B: res = WIDTH'(rs < imm_s);
      6'h0C: res = rs & imm_z;
      6'h0D: res = rs | imm_z;
      6'h0E: res = rs ^ imm_z;
      6'h0F: res = lui_val;
      default: res = '0;
    endcase
  end

  // One shift-add step: add multiplicand when the current multiplier LSB is
  // set, then shift the whole accumulator right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step: shift in the next dividend bit and subtract
  // the divisor if it fits.
  logic [WIDTH:0]     div_part, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_part = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, opnd_q};
  assign div_ge   = (div_part >= {1'b0, opnd_q});
  assign div_next = {div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  assign acc_neg = -acc_q;
  assign a_mag   = (md_signed && rs[WIDTH-1]) ? -rs : rs;
  assign b_mag   = (md_signed && rt[WIDTH-1]) ? -rt : rt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    rs_sv_d     = rs_sv_q;
    div_d       = div_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = fire && !md_start;
    data_d      = data_q;
    ovf_d       = ovf_q;
    if (fire && !md_start) begin
      data_d = res;
      ovf_d  = ovf;
    end
    case (state_q)
      S_IDLE: begin
        if (fire && md_start) begin
          state_d = S_RUN;
          cnt_d   = SHW'(WIDTH - 1);
          div_d   = md_div;
          neg_d   = md_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
          rneg_d  = md_signed && rs[WIDTH-1];
          dz_d    = (rt == '0);
          rs_sv_d = rs;
          if (md_div) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!div_q) begin
          {hi_d, lo_d} = neg_q ? acc_neg : acc_q;
        end else if (dz_q) begin
          hi_d = rs_sv_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q  ? acc_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      rs_sv_q     <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      rs_sv_q     <= rs_sv_d;
      div_q       <= div_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed vectors for execute_unit (WIDTH=32).
// Drives inputs and samples outputs 1ns after the rising edge.
// Table of single-cycle ops streamed back-to-back, plus mul/div/reset sequences.
module tb_execute_unit;
  logic        clock, reset, in_valid, in_ready, out_valid, overflow, busy;
  logic [31:0] insn, pc, rs, rt, data_out;

  int tests    = 0;
  int failures = 0;

  execute_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .insn(insn), .pc(pc), .rs(rs), .rt(rt),
    .out_valid(out_valid), .data_out(data_out), .overflow(overflow), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
    F_SRLV = 6'h06, F_SRAV = 6'h07, F_JALR = 6'h09, F_MFHI = 6'h10, F_MFLO = 6'h12,
    F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B, F_ADD = 6'h20,
    F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
    F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [5:0] O_ADDI = 6'h08, O_ADDIU = 6'h09, O_SLTI = 6'h0A, O_SLTIU = 6'h0B,
    O_ANDI = 6'h0C, O_ORI = 6'h0D, O_XORI = 6'h0E, O_LUI = 6'h0F;

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sa);
    return {6'd0, 15'd0, sa, f};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] i, a, b, p, e, input logic o);
    vec_t v;
    v.insn = i; v.rs = a; v.rt = b; v.pc = p; v.exp = e; v.ovf = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Single-cycle op: accept at next edge, result visible right after it.
  task automatic single(input string name, input logic [31:0] i, a, b, e, input logic o);
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    insn = i; rs = a; rt = b; pc = 32'h0; in_valid = 1'b1;
    @(posedge clock); #1;
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({name, ".data"}, data_out, e);
    check({name, ".ovf"}, 32'(overflow), 32'(o));
    in_valid = 1'b0;
  endtask

  // Mul/div followed by a stalled ADD 1+2 presented throughout the stall.
  task automatic run_muldiv(input string name, input logic [31:0] i, a, b);
    int busy_cnt, bad, n;
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    insn = i; rs = a; rt = b; in_valid = 1'b1;
    @(posedge clock); #1;
    insn = rtype(F_ADD, 5'd0); rs = 32'd1; rt = 32'd2;
    busy_cnt = 0; bad = 0; n = 0;
    while (busy && n < 200) begin
      busy_cnt++;
      if (in_ready || out_valid) bad++;
      @(posedge clock); #1;
      n++;
    end
    check({name, ".busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({name, ".stall_violations"}, 32'(bad), 32'd0);
    @(posedge clock); #1;
    check({name, ".stalled_add_vld"}, 32'(out_valid), 32'd1);
    check({name, ".stalled_add_data"}, data_out, 32'd3);
    in_valid = 1'b0;
  endtask

  initial begin
    int quiet;
    reset = 1'b1; in_valid = 1'b0; insn = '0; pc = '0; rs = '0; rt = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.data_out", data_out, 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);

    vecs.push_back(mk(rtype(F_MFHI, 0), 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(rtype(F_MFLO, 0), 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(rtype(F_ADD, 0), 5, 7, 0, 32'd12, 0));
    vecs.push_back(mk(rtype(F_ADD, 0), 32'h7FFFFFFF, 1, 0, 32'h80000000, 1));
    vecs.push_back(mk(rtype(F_ADDU, 0), 32'h7FFFFFFF, 1, 0, 32'h80000000, 0));
    vecs.push_back(mk(rtype(F_SUB, 0), 32'h80000000, 1, 0, 32'h7FFFFFFF, 1));
    vecs.push_back(mk(rtype(F_SUBU, 0), 3, 5, 0, 32'hFFFFFFFE, 0));
    vecs.push_back(mk(rtype(F_AND, 0), 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0));
    vecs.push_back(mk(rtype(F_OR, 0), 32'h12340000, 32'h00005678, 0, 32'h12345678, 0));
    vecs.push_back(mk(rtype(F_SLT, 0), 32'hFFFFFFFF, 1, 0, 32'd1, 0));
    vecs.push_back(mk(rtype(F_SLTU, 0), 32'hFFFFFFFF, 1, 0, 32'd0, 0));
    vecs.push_back(mk(itype(O_XORI, 16'h0F0F), 32'h0000FFFF, 0, 0, 32'h0000F0F0, 0));
    vecs.push_back(mk(rtype(F_NOR, 0), 0, 0, 0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(rtype(F_XOR, 0), 32'hAAAA5555, 32'hFFFF0000, 0, 32'h55555555, 0));
    vecs.push_back(mk(rtype(F_SRA, 5'd4), 0, 32'h80000000, 0, 32'hF8000000, 0));
    vecs.push_back(mk(rtype(F_SRL, 5'd4), 0, 32'h80000000, 0, 32'h08000000, 0));
    vecs.push_back(mk(rtype(F_SLL, 5'd31), 0, 32'h00000001, 0, 32'h80000000, 0));
    vecs.push_back(mk(rtype(F_SLLV, 0), 32'h24, 32'h0000000F, 0, 32'h000000F0, 0));
    vecs.push_back(mk(rtype(F_SRAV, 0), 32'h1F, 32'h80000000, 0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(rtype(F_SRLV, 0), 32'h8, 32'h12345678, 0, 32'h00123456, 0));
    vecs.push_back(mk(itype(O_LUI, 16'h1234), 0, 0, 0, 32'h12340000, 0));
    vecs.push_back(mk(itype(O_ADDI, 16'h0001), 32'h7FFFFFFF, 0, 0, 32'h80000000, 1));
    vecs.push_back(mk(itype(O_ADDI, 16'hFFFF), 32'h80000000, 0, 0, 32'h7FFFFFFF, 1));
    vecs.push_back(mk(itype(O_ADDIU, 16'hFFFF), 5, 0, 0, 32'd4, 0));
    vecs.push_back(mk(itype(O_SLTI, 16'hFFFF), 32'hFFFFFFFE, 0, 0, 32'd1, 0));
    vecs.push_back(mk(itype(O_SLTIU, 16'hFFFF), 5, 0, 0, 32'd1, 0));
    vecs.push_back(mk(itype(O_ANDI, 16'h8001), 32'hFFFFFFFF, 0, 0, 32'h00008001, 0));
    vecs.push_back(mk(itype(O_ORI, 16'h8000), 32'h12340000, 0, 0, 32'h12348000, 0));
    vecs.push_back(mk(rtype(F_JALR, 0), 0, 0, 32'h00400010, 32'h00400018, 0));
    vecs.push_back(mk({6'h3F, 26'h0}, 1, 1, 0, 32'h0, 0));
    vecs.push_back(mk(rtype(6'h3F, 0), 32'hFFFFFFFF, 1, 0, 32'h0, 0));
    vecs.push_back(mk(rtype(F_SLT, 0), 1, 32'hFFFFFFFF, 0, 32'd0, 0));

    // Stream the table back-to-back: one op accepted per edge.
    foreach (vecs[k]) begin
      insn = vecs[k].insn; rs = vecs[k].rs; rt = vecs[k].rt; pc = vecs[k].pc;
      in_valid = 1'b1;
      @(posedge clock); #1;
      check($sformatf("vec[%0d].out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("vec[%0d].data", k), data_out, vecs[k].exp);
      check($sformatf("vec[%0d].ovf", k), 32'(overflow), 32'(vecs[k].ovf));
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("stream_end.out_valid", 32'(out_valid), 32'd0);

    run_muldiv("mult", rtype(F_MULT, 0), 32'hFFFFFFFD, 32'd7);
    single("mult.mflo", rtype(F_MFLO, 0), 0, 0, 32'hFFFFFFEB, 0);
    single("mult.mfhi", rtype(F_MFHI, 0), 0, 0, 32'hFFFFFFFF, 0);

    run_muldiv("multu", rtype(F_MULTU, 0), 32'hFFFFFFFF, 32'hFFFFFFFF);
    single("multu.mfhi", rtype(F_MFHI, 0), 0, 0, 32'hFFFFFFFE, 0);
    single("multu.mflo", rtype(F_MFLO, 0), 0, 0, 32'h00000001, 0);

    run_muldiv("div_n7_2", rtype(F_DIV, 0), 32'hFFFFFFF9, 32'd2);
    single("div_n7_2.mflo", rtype(F_MFLO, 0), 0, 0, 32'hFFFFFFFD, 0);
    single("div_n7_2.mfhi", rtype(F_MFHI, 0), 0, 0, 32'hFFFFFFFF, 0);

    run_muldiv("div_7_n2", rtype(F_DIV, 0), 32'd7, 32'hFFFFFFFE);
    single("div_7_n2.mflo", rtype(F_MFLO, 0), 0, 0, 32'hFFFFFFFD, 0);
    single("div_7_n2.mfhi", rtype(F_MFHI, 0), 0, 0, 32'h00000001, 0);

    run_muldiv("divu_100_7", rtype(F_DIVU, 0), 32'd100, 32'd7);
    single("divu_100_7.mflo", rtype(F_MFLO, 0), 0, 0, 32'd14, 0);
    single("divu_100_7.mfhi", rtype(F_MFHI, 0), 0, 0, 32'd2, 0);

    run_muldiv("divu_5_0", rtype(F_DIVU, 0), 32'd5, 32'd0);
    single("divu_5_0.mfhi", rtype(F_MFHI, 0), 0, 0, 32'd5, 0);
    single("divu_5_0.mflo", rtype(F_MFLO, 0), 0, 0, 32'hFFFFFFFF, 0);

    // Abort a DIV with reset ten cycles in; HI still holds 5 beforehand.
    insn = rtype(F_DIV, 0); rs = 32'd100; rt = 32'd7; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("abort.busy_before", 32'(busy), 32'd1);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    quiet = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (out_valid || busy) quiet++;
    end
    check("abort.spurious", 32'(quiet), 32'd0);
    single("abort.mfhi", rtype(F_MFHI, 0), 0, 0, 32'd0, 0);
    single("abort.mflo", rtype(F_MFLO, 0), 0, 0, 32'd0, 0);
    single("abort.add", rtype(F_ADD, 0), 32'd20, 32'd22, 32'd42, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
